spike_window_gen: RTL

SPIKE_WINDOW_GEN -- requirements
Module: spike_window_gen

---
 rtl/spike_window_gen.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spike_window_gen.sv
// Sliding K x K spike-window generator for a raster pixel stream, with line buffers and frame/time-step sequencing.
// Optional idle power-down request is built only when IDLE_PD_EN is defined.
//
// state   | meaning
// S_IDLE  | counters at 0, no window pending, config follows CFG_* inputs
// S_RUN   | frame pixels being accepted, config frozen
// S_FLUSH | last pixel of last frame taken, waiting for final window to leave
module spike_window_gen #(
  parameter int CH        = 16,
  parameter int K         = 3,
  parameter int HW_WIDTH  = 5,
  parameter int T_WIDTH   = 5,
  parameter int TPD_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic [HW_WIDTH-1:0]   CFG_W,
  input  logic [HW_WIDTH-1:0]   CFG_H,
  input  logic [T_WIDTH-1:0]    CFG_T,
  input  logic                  CFG_S2,
  input  logic [TPD_WIDTH-1:0]  TPD,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [CH-1:0]         IN_SPIKE,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [K*K*CH-1:0]     OUT_WINDOW,
  output logic                  FRAME_DONE,
  output logic                  DONE,
  output logic                  PD
);

  localparam int DEPTH = 2**HW_WIDTH;
  localparam logic [HW_WIDTH-1:0] KM1 = HW_WIDTH'(K-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
  state_t r_state, w_state_nxt;

  logic [HW_WIDTH-1:0] r_cfg_w, r_cfg_h, r_col, r_row;
  logic [T_WIDTH-1:0]  r_cfg_t, r_t;
  logic                r_cfg_s2;
  logic                r_out_valid, r_frame_done, r_done;
  logic [K*K*CH-1:0]   r_out_window;

  logic [HW_WIDTH-1:0] w_cfg_w, w_cfg_h;
  logic [T_WIDTH-1:0]  w_cfg_t;
  logic                w_cfg_s2, w_idle, w_pd, w_accept, w_emit;
  logic                w_col_last, w_row_last, w_t_last, w_frame_end, w_run_end;
  logic                w_row_even, w_col_even;

  // Column 0 of the held window is dropped on the next shift, so only columns 1..K-1 are kept.
  logic [CH-1:0]       r_lb  [K-1][DEPTH];
  logic [CH-1:0]       r_win [K][K-1];
  logic [CH-1:0]       w_win_nxt [K][K];
  logic [K*K*CH-1:0]   w_win_flat;

  assign w_idle   = (r_state == S_IDLE);
  assign w_cfg_w  = w_idle ? CFG_W  : r_cfg_w;
  assign w_cfg_h  = w_idle ? CFG_H  : r_cfg_h;
  assign w_cfg_t  = w_idle ? CFG_T  : r_cfg_t;
  assign w_cfg_s2 = w_idle ? CFG_S2 : r_cfg_s2;

  assign IN_READY = (!r_out_valid || OUT_READY) && !w_pd;
  assign w_accept = IN_VALID && IN_READY;

  assign w_col_last  = (r_col == w_cfg_w);
  assign w_row_last  = (r_row == w_cfg_h);
  assign w_t_last    = (r_t == w_cfg_t);
  assign w_frame_end = w_col_last && w_row_last;
  assign w_run_end   = w_frame_end && w_t_last;

  assign w_row_even = !(r_row[0] ^ KM1[0]);
  assign w_col_even = !(r_col[0] ^ KM1[0]);
  assign w_emit = w_accept && (r_row >= KM1) && (r_col >= KM1) &&
                  (!w_cfg_s2 || (w_row_even && w_col_even));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_RUN: if (w_accept) w_state_nxt = w_run_end ? S_FLUSH : S_RUN;
      S_FLUSH: begin
        if (w_accept)                        w_state_nxt = w_run_end ? S_FLUSH : S_RUN;
        else if (!r_out_valid || OUT_READY)  w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_cfg_w      <= '0;
      r_cfg_h      <= '0;
      r_cfg_t      <= '0;
      r_cfg_s2     <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_t          <= '0;
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_frame_done <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_idle) begin
        r_cfg_w  <= CFG_W;
        r_cfg_h  <= CFG_H;
        r_cfg_t  <= CFG_T;
        r_cfg_s2 <= CFG_S2;
      end
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          if (w_row_last) begin
            r_row <= '0;
            r_t   <= w_t_last ? '0 : r_t + T_WIDTH'(1);
          end else begin
            r_row <= r_row + HW_WIDTH'(1);
          end
        end else begin
          r_col <= r_col + HW_WIDTH'(1);
        end
      end
      r_frame_done <= w_accept && w_frame_end;
      r_done       <= w_accept && w_run_end;
      if (w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_window <= w_win_flat;
      end else if (OUT_READY) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  // New right-hand column: oldest line buffer feeds the top row, the live pixel the bottom row.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) w_win_nxt[r][c] = r_win[r][c];
      w_win_nxt[r][K-1] = (r == K-1) ? IN_SPIKE : r_lb[K-2-r][r_col];
    end
  end

  always_comb begin
    w_win_flat = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w_win_flat[(r*K+c)*CH +: CH] = w_win_nxt[r][c];
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K-1; c++)
          r_win[r][c] <= w_win_nxt[r][c+1];
      r_lb[0][r_col] <= IN_SPIKE;
      for (int j = 1; j < K-1; j++) r_lb[j][r_col] <= r_lb[j-1][r_col];
    end
  end

`ifdef IDLE_PD_EN
  logic [TPD_WIDTH-1:0] r_idle_cnt;
  logic                 r_pd;
  logic [TPD_WIDTH:0]   w_idle_cnt_inc;

  assign w_idle_cnt_inc = {1'b0, r_idle_cnt} + (TPD_WIDTH+1)'(1);

  // Wake takes one cycle: PD drops after IN_VALID is seen, and IN_READY stays low meanwhile.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_idle_cnt <= '0;
      r_pd       <= 1'b0;
    end else if (!w_idle || IN_VALID) begin
      r_idle_cnt <= '0;
      if (IN_VALID) r_pd <= 1'b0;
    end else if (!r_pd) begin
      r_idle_cnt <= w_idle_cnt_inc[TPD_WIDTH-1:0];
      if (w_idle_cnt_inc >= {1'b0, TPD}) r_pd <= 1'b1;
    end
  end

  assign w_pd = r_pd;
`else
  logic w_unused_tpd;
  assign w_unused_tpd = ^TPD;
  assign w_pd = 1'b0;
`endif

  assign OUT_VALID  = r_out_valid;
  assign OUT_WINDOW = r_out_window;
  assign FRAME_DONE = r_frame_done;
  assign DONE       = r_done;
  assign PD         = w_pd;

endmodule
